// File: rtl/loader_pkg.sv
// loader_pkg: shared states, defaults and sizing helpers for uart_word_loader
package loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  localparam int DEF_NB_DATA = 32;
  localparam int DEF_N_BITS = 8;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFFFFFF;
  function automatic int bytes_per_word(input int nb_data, input int n_bits);
    return nb_data / n_bits;
  endfunction
  function automatic int idx_width(input int bpw);
    return bpw > 1 ? $clog2(bpw) : 1;
  endfunction
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs N_BITS bytes into an NB_DATA word, pulsing word_ready on the final byte
module word_assembler import loader_pkg::*; #(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int N_BITS = DEF_N_BITS,
  parameter int BIG_END = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [N_BITS-1:0]  data,
  output logic [NB_DATA-1:0] word,
  output logic               word_ready
);
  localparam int BPW = bytes_per_word(NB_DATA, N_BITS);
  localparam int IW = idx_width(BPW);
  logic [IW-1:0] idx;
  logic [NB_DATA-1:0] acc;
  // word is the accumulator with the incoming byte already in its lane
  always_comb begin
    word = acc;
    for (int i = 0; i < BPW; i++)
      if (idx == IW'(i)) word[(BIG_END != 0 ? BPW - 1 - i : i) * N_BITS +: N_BITS] = data;
    word_ready = en && idx == IW'(BPW - 1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idx <= '0;
      acc <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      acc <= word;
      idx <= word_ready ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes into words and writes them to instruction memory until halt or full.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum byte check (CHECK state, chk_err_o).
module uart_word_loader import loader_pkg::*; #(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int N_BITS = DEF_N_BITS,
  parameter int NB_ADDR = 7,
  parameter int ADDR_STEP = 4,
  parameter int BIG_END = 1,
  parameter logic [NB_DATA-1:0] HALT_WORD = NB_DATA'(DEF_HALT_WORD)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic               rx_done_i,
  input  logic [N_BITS-1:0]  rx_data_i,
  output logic               mem_we_o,
  output logic [NB_ADDR-1:0] mem_addr_o,
  output logic [NB_DATA-1:0] mem_data_o,
  output logic               busy_o,
  output logic               finish_o,
  output logic               overflow_o,
  output logic [NB_ADDR-1:0] word_cnt_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic               chk_err_o
`endif
);
  state_t state, nxt;
  logic [NB_ADDR-1:0] addr;
  logic [NB_ADDR:0] addr_sum;
  logic halt_q, ovf_q, accept, word_ready, is_halt, wrap;
  logic [NB_DATA-1:0] word;
  assign addr_sum = {1'b0, addr} + (NB_ADDR + 1)'(ADDR_STEP);
  assign wrap = addr_sum[NB_ADDR];
  assign is_halt = word == HALT_WORD;
  // halt_q/ovf_q mark the word being strobed as the last of the load; later bytes are ignored
  assign accept = state == LOAD && rx_done_i && !start_i && !halt_q && !ovf_q;
  assign busy_o = state == LOAD;
  assign finish_o = state == DONE;
  word_assembler #(.NB_DATA(NB_DATA), .N_BITS(N_BITS), .BIG_END(BIG_END)) u_asm (
    .clock(clock),
    .reset(reset),
    .clr(start_i),
    .en(accept),
    .data(rx_data_i),
    .word(word),
    .word_ready(word_ready)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (start_i) nxt = LOAD;
    else if (state == LOAD && ovf_q) nxt = DONE;
`ifdef LOADER_CHECKSUM_EN
    else if (state == LOAD && halt_q) nxt = CHECK;
    else if (state == CHECK && rx_done_i) nxt = DONE;
`else
    else if (state == LOAD && halt_q) nxt = DONE;
`endif
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      addr <= '0;
      word_cnt_o <= '0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      halt_q <= 1'b0;
      ovf_q <= 1'b0;
      overflow_o <= 1'b0;
    end else if (start_i) begin
      addr <= '0;
      word_cnt_o <= '0;
      mem_we_o <= 1'b0;
      halt_q <= 1'b0;
      ovf_q <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      mem_we_o <= word_ready;
      if (word_ready) begin
        mem_addr_o <= addr;
        mem_data_o <= word;
        halt_q <= is_halt;
        ovf_q <= !is_halt && wrap;
        if (!wrap) addr <= addr_sum[NB_ADDR-1:0];
        if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + 1'b1;
      end
      if (state == LOAD && ovf_q) overflow_o <= 1'b1;
    end
`ifdef LOADER_CHECKSUM_EN
  logic [N_BITS-1:0] csum;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      csum <= '0;
      chk_err_o <= 1'b0;
    end else if (start_i) begin
      csum <= '0;
      chk_err_o <= 1'b0;
    end else begin
      if (accept) csum <= csum + rx_data_i;
      if (state == CHECK && rx_done_i) chk_err_o <= rx_data_i != csum;
    end
`endif
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: three loader variants (big-endian, little-endian, 4-bit address) on shared stimulus
module tb_uart_word_loader;
  logic clock = 1'b0, reset = 1'b1, start_i = 1'b0, rx_done_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic [2:0] we, busy, fin, ovf;
  logic [2:0][31:0] data;
  logic [6:0] addr0, addr1, cnt0, cnt1;
  logic [3:0] addr2, cnt2;
`ifdef LOADER_CHECKSUM_EN
  logic [2:0] cerr;
  localparam logic HF = 1'b0;
`else
  localparam logic HF = 1'b1;
`endif
  always #5 clock = ~clock;

  uart_word_loader #(.BIG_END(1)) dut (
    .clock(clock),
`ifdef LOADER_CHECKSUM_EN
    .chk_err_o(cerr[0]),
`endif
    .reset(reset), .start_i(start_i), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
    .mem_we_o(we[0]), .mem_addr_o(addr0), .mem_data_o(data[0]), .busy_o(busy[0]),
    .finish_o(fin[0]), .overflow_o(ovf[0]), .word_cnt_o(cnt0));
  uart_word_loader #(.BIG_END(0)) dut_le (
    .clock(clock),
`ifdef LOADER_CHECKSUM_EN
    .chk_err_o(cerr[1]),
`endif
    .reset(reset), .start_i(start_i), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
    .mem_we_o(we[1]), .mem_addr_o(addr1), .mem_data_o(data[1]), .busy_o(busy[1]),
    .finish_o(fin[1]), .overflow_o(ovf[1]), .word_cnt_o(cnt1));
  uart_word_loader #(.NB_ADDR(4)) dut_small (
    .clock(clock),
`ifdef LOADER_CHECKSUM_EN
    .chk_err_o(cerr[2]),
`endif
    .reset(reset), .start_i(start_i), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
    .mem_we_o(we[2]), .mem_addr_o(addr2), .mem_data_o(data[2]), .busy_o(busy[2]),
    .finish_o(fin[2]), .overflow_o(ovf[2]), .word_cnt_o(cnt2));

  typedef struct packed {logic [6:0] a; logic [31:0] d;} wr_t;
  typedef struct {
    bit start; logic [31:0] w;
    logic busy_a, fin_a; int cnt_a;
    logic busy_c, fin_c, ovf_c; int cnt_c;
  } vec_t;
  wr_t q0[$], q1[$], q2[$];
  int n_cmp = 0, n_err = 0;
  int m_addr[3];
  bit m_done[3];
  int nb[3] = '{7, 7, 4};
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_wr(input int i, input logic [6:0] a, input logic [31:0] d);
    wr_t e;
    int sz;
    sz = i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
    if (sz == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wr%0d_unexpected: got strobe addr %h data %h expected none", i, a, d);
    end else begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("wr%0d_addr", i), 32'(a), 32'(e.a));
      chk($sformatf("wr%0d_data", i), d, e.d);
    end
  endtask

  always @(negedge clock) begin
    if (we[0]) check_wr(0, addr0, data[0]);
    if (we[1]) check_wr(1, addr1, data[1]);
    if (we[2]) check_wr(2, {3'b0, addr2}, data[2]);
  end

  task automatic model_word(input logic [31:0] w);
    wr_t e;
    for (int i = 0; i < 3; i++)
      if (!m_done[i]) begin
        e.a = 7'(m_addr[i]);
        e.d = i == 1 ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
        case (i)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
        if (w == 32'hFFFFFFFF || m_addr[i] + 4 >= (1 << nb[i])) m_done[i] = 1'b1;
        else m_addr[i] += 4;
      end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(posedge clock);
    #1;
    rx_done_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    model_word(w);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clock);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = 0;
      m_done[i] = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{1, 32'h01020304, 1, 0, 1, 1, 0, 0, 1};
    tbl[1] = '{1, 32'hA0A1A2A3, 1, 0, 1, 1, 0, 0, 1};
    tbl[2] = '{0, 32'hB0B1B2B3, 1, 0, 2, 1, 0, 0, 2};
    tbl[3] = '{0, 32'hC0C1C2C3, 1, 0, 3, 1, 0, 0, 3};
    tbl[4] = '{0, 32'hFFFFFFFF, 0, HF, 4, 0, HF, 0, 4};
    tbl[5] = '{1, 32'h10000001, 1, 0, 1, 1, 0, 0, 1};
    tbl[6] = '{0, 32'h20000002, 1, 0, 2, 1, 0, 0, 2};
    tbl[7] = '{0, 32'h30000003, 1, 0, 3, 1, 0, 0, 3};
    tbl[8] = '{0, 32'h40000004, 1, 0, 4, 0, 1, 1, 4};
    tbl[9] = '{0, 32'h50000005, 1, 0, 5, 0, 1, 1, 4};
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = 0;
      m_done[i] = 1'b1;
    end
    idle(2);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fin", 32'(fin), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_addr", 32'(addr0), 0);
    chk("rst_data", data[0], 0);
    reset = 1'b0;
    idle(1);
    send_word(32'h55AA55AA);
    idle(3);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cnt", 32'(cnt0), 0);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].start) pulse_start();
      send_word(tbl[i].w);
      idle(3);
      chk($sformatf("v%0d_busy_a", i), 32'(busy[0]), 32'(tbl[i].busy_a));
      chk($sformatf("v%0d_fin_a", i), 32'(fin[0]), 32'(tbl[i].fin_a));
      chk($sformatf("v%0d_cnt_a", i), 32'(cnt0), 32'(tbl[i].cnt_a));
      chk($sformatf("v%0d_ovf_a", i), 32'(ovf[0]), 0);
      chk($sformatf("v%0d_busy_b", i), 32'(busy[1]), 32'(tbl[i].busy_a));
      chk($sformatf("v%0d_cnt_b", i), 32'(cnt1), 32'(tbl[i].cnt_a));
      chk($sformatf("v%0d_busy_c", i), 32'(busy[2]), 32'(tbl[i].busy_c));
      chk($sformatf("v%0d_fin_c", i), 32'(fin[2]), 32'(tbl[i].fin_c));
      chk($sformatf("v%0d_ovf_c", i), 32'(ovf[2]), 32'(tbl[i].ovf_c));
      chk($sformatf("v%0d_cnt_c", i), 32'(cnt2), 32'(tbl[i].cnt_c));
    end
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    pulse_start();
    send_word(32'hAABBCCDD);
    idle(3);
    chk("partial_cnt", 32'(cnt0), 1);
    send_word(32'h11223344);
    send_word(32'h55667788);
    idle(3);
    chk("burst_cnt", 32'(cnt0), 3);
    chk("burst_cnt_c", 32'(cnt2), 3);
    send_byte(8'h9A);
    send_byte(8'hBC);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(cnt0), 0);
    chk("arst_addr", 32'(addr0), 0);
    chk("arst_data", data[0], 0);
    chk("arst_we", 32'(we), 0);
    for (int i = 0; i < 3; i++) m_done[i] = 1'b1;
    idle(1);
    reset = 1'b0;
    pulse_start();
    send_word(32'hDEADBEEF);
    idle(3);
    chk("post_rst_cnt", 32'(cnt0), 1);
`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_word(32'h01020304);
    send_word(32'hFFFFFFFF);
    idle(3);
    chk("ck_wait_fin", 32'(fin[0]), 0);
    chk("ck_wait_busy", 32'(busy[0]), 0);
    send_byte(8'h06);
    idle(2);
    chk("ck_good_fin", 32'(fin[0]), 1);
    chk("ck_good_err", 32'(cerr), 0);
    pulse_start();
    send_word(32'h01020304);
    send_word(32'hFFFFFFFF);
    idle(3);
    send_byte(8'h07);
    idle(2);
    chk("ck_bad_fin", 32'(fin[0]), 1);
    chk("ck_bad_err", 32'(cerr), 32'h7);
`endif
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
